frame_manager_multi: RTL and testbench
======================================

// Module: frame_manager_multi
// PURPOSE
//  Single-clock, double-buffered, down-scaled framebuffer shared by NUM_SOURCES draw engines.
//  Grants the write bus to enabled sources one at a time and can clear the back buffer after each swap.
//  Swaps buffers on a frame pulse and counts missed frames.
//  Sits between the draw engines (writers) and the VGA pixel pipeline (1-cycle reader).
// PARAMETERS
//  NUM_SOURCES    2    number of write sources; SEL_W = max(1,$clog2(NUM_SOURCES))
//  COLOR_DEPTH    8    bits per stored pixel
//  DRAW_WIDTH     640  logical width; XW = $clog2(DRAW_WIDTH)
//  DRAW_HEIGHT    480  logical height; YW = $clog2(DRAW_HEIGHT)
//  SCALE_SHR      1    downscale shift; SW = DRAW_WIDTH>>SCALE_SHR, SH = DRAW_HEIGHT>>SCALE_SHR
//  CLEAR_ON_SWAP  1    1: sweep the back buffer with CLEAR_COLOR before granting any source
//  CLEAR_COLOR    0    fill value; also returned for out-of-range reads
// PORTS
//  clk               in   1            single clock for the write and read sides
//  resetN            in   1            async active-low reset
//  frame             in   1            1-cycle frame-boundary pulse
//  source_enable     in   NUM_SOURCES  per-source participation mask, sampled in SIGNAL
//  write_active      in   1            granted source is writing
//  write_transparent in   1            suppress the current pixel write
//  write_color_data  in   COLOR_DEPTH  pixel colour
//  write_x_addr      in   XW           logical x
//  write_y_addr      in   YW           logical y
//  write_awaited     out  1            registered; grant strobe to source write_source_sel
//  write_source_sel  out  SEL_W        index of the granted source
//  read_x_addr       in   XW           logical x, front buffer
//  read_y_addr       in   YW           logical y, front buffer
//  read_color_data   out  COLOR_DEPTH  front-buffer pixel, 1-cycle latency
//  clear_busy        out  1            back-buffer sweep in progress
//  frames_missed     out  8            saturating count of frame pulses not taken for a swap
// BEHAVIOUR
//  Storage and addressing
//  - Two SW*SH-deep RAMs. active_fb selects the front buffer; the other is the back buffer.
//  - addr = (y>>SCALE_SHR)*SW + (x>>SCALE_SHR), sized to $clog2(SW*SH) bits.
//  Reset (async)
//  - active_fb=0, sel=0, write_awaited=0, frames_missed=0, clear_addr=0, read_color_data=0.
//  - State goes to CLEAR if CLEAR_ON_SWAP=1, else SIGNAL.
//  - clear_busy = (state==CLEAR); it is 1 out of reset when CLEAR_ON_SWAP=1.
//  - A reset mid-frame abandons the frame. Back-buffer contents are not guaranteed.
//  FSM states
//  - CLEAR: write CLEAR_COLOR to back[clear_addr], clear_addr++ each cycle.
//    At SW*SH-1 go to SIGNAL with sel=0. Source writes are ignored here.
//  - SIGNAL: if source_enable[sel]=1, go to AWAIT_WRITE and set write_awaited=1.
//    Otherwise go to DONE without granting (skip).
//  - AWAIT_WRITE: go to WRITING when write_active=1; write_awaited clears on that edge.
//  - WRITING: stay while write_active=1; go to DONE on the first cycle it is 0.
//  - DONE: if sel==NUM_SOURCES-1, set sel=0 and go to AWAIT_SWAP. Otherwise sel++ and go to SIGNAL.
//  - AWAIT_SWAP: on frame=1, toggle active_fb and go to CLEAR (or SIGNAL if CLEAR_ON_SWAP=0).
//  Write rules
//  - A back-buffer write happens when all of these hold: state is AWAIT_WRITE or WRITING,
//    write_active=1, write_transparent=0, x<DRAW_WIDTH and y<DRAW_HEIGHT.
//  - Writes with out-of-range coordinates are dropped silently.
//  - The front buffer is never written.
//  Frame and overrun
//  - A frame pulse in any state other than AWAIT_SWAP increments frames_missed (saturates at 255).
//    No swap happens; the frame being drawn completes and waits for the next pulse.
//  - If every source is disabled, the FSM walks SIGNAL->DONE for each index in 2*NUM_SOURCES cycles,
//    then waits in AWAIT_SWAP.
//  Read path
//  - read_color_data is registered, 1-cycle latency.
//  - Buffer select is the active_fb value in the address cycle, piped alongside the RAM read,
//    so a swap never mixes buffers within one read.
//  - Out-of-range read coordinates return CLEAR_COLOR.
// TESTING (NUM_SOURCES=2, DRAW 16x8, SCALE_SHR=1 -> 8x4=32 words, CLEAR_COLOR=8'h00)
//  1. Release reset -> clear_busy=1 for exactly 32 cycles, then write_awaited=1 with sel=0.
//  2. Src0 writes (2,2)=8'hA5, src1 writes (3,2)=8'h3C with transparent=1; frame pulse;
//     read (2,2)/(3,2) -> 8'hA5/8'h00 one cycle later.
//  3. source_enable=2'b10 -> src0 is never granted; src1 granted with sel=1 after CLEAR.
//  4. Three frame pulses during WRITING -> frames_missed=3, active_fb unchanged.
//     Frame pulse in AWAIT_SWAP -> swap.
//  5. Write x=16 (out of range) -> no RAM write. Read x=16 -> CLEAR_COLOR.
//     300 missed frames -> frames_missed=255.
//  6. Assert resetN mid-WRITING -> write_awaited=0 and sel=0 immediately;
//     CLEAR restarts at addr 0; frames_missed=0.

Source files
------------

// File: rtl/frame_manager_multi.sv
// frame_manager_multi: double-buffered, downscaled framebuffer shared by several draw sources,
// with round-robin write grants, optional back-buffer clear after swap and missed-frame counting.
module frame_manager_multi #(
  parameter int NUM_SOURCES = 2,
  parameter int COLOR_DEPTH = 8,
  parameter int DRAW_WIDTH = 640,
  parameter int DRAW_HEIGHT = 480,
  parameter int SCALE_SHR = 1,
  parameter int CLEAR_ON_SWAP = 1,
  parameter logic [COLOR_DEPTH-1:0] CLEAR_COLOR = '0,
  localparam int SEL_W = NUM_SOURCES > 1 ? $clog2(NUM_SOURCES) : 1,
  localparam int XW = $clog2(DRAW_WIDTH),
  localparam int YW = $clog2(DRAW_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   frame,
  input  logic [NUM_SOURCES-1:0] source_enable,
  input  logic                   write_active,
  input  logic                   write_transparent,
  input  logic [COLOR_DEPTH-1:0] write_color_data,
  input  logic [XW-1:0]          write_x_addr,
  input  logic [YW-1:0]          write_y_addr,
  output logic                   write_awaited,
  output logic [SEL_W-1:0]       write_source_sel,
  input  logic [XW-1:0]          read_x_addr,
  input  logic [YW-1:0]          read_y_addr,
  output logic [COLOR_DEPTH-1:0] read_color_data,
  output logic                   clear_busy,
  output logic [7:0]             frames_missed
);
  localparam int SW = DRAW_WIDTH >> SCALE_SHR;
  localparam int SH = DRAW_HEIGHT >> SCALE_SHR;
  localparam int DEPTH = SW * SH;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {CLEAR, SIGNAL, AWAIT_WRITE, WRITING, DONE, AWAIT_SWAP} state_t;
  localparam state_t REFILL = (CLEAR_ON_SWAP != 0) ? CLEAR : SIGNAL;

  function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'((32'(y) >> SCALE_SHR) * 32'(SW) + (32'(x) >> SCALE_SHR));
  endfunction

  function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return 32'(x) < 32'(DRAW_WIDTH) && 32'(y) < 32'(DRAW_HEIGHT);
  endfunction

  state_t state, next;
  logic [AW-1:0] clear_addr, waddr, raddr;
  logic [COLOR_DEPTH-1:0] wdata;
  logic [COLOR_DEPTH-1:0] mem0 [DEPTH];
  logic [COLOR_DEPTH-1:0] mem1 [DEPTH];
  logic active_fb, clear_last, last_sel, we, rd_ok;

  assign clear_busy = state == CLEAR;
  assign clear_last = clear_addr == AW'(DEPTH - 1);
  assign last_sel = write_source_sel == SEL_W'(NUM_SOURCES - 1);
  assign we = clear_busy || ((state == AWAIT_WRITE || state == WRITING) && write_active &&
              !write_transparent && in_range(write_x_addr, write_y_addr));
  assign waddr = clear_busy ? clear_addr : addr_of(write_x_addr, write_y_addr);
  assign wdata = clear_busy ? CLEAR_COLOR : write_color_data;
  assign raddr = addr_of(read_x_addr, read_y_addr);
  assign rd_ok = in_range(read_x_addr, read_y_addr);

  always_comb begin
    next = state;
    case (state)
      CLEAR:       next = clear_last ? SIGNAL : CLEAR;
      SIGNAL:      next = source_enable[write_source_sel] ? AWAIT_WRITE : DONE;
      AWAIT_WRITE: next = write_active ? WRITING : AWAIT_WRITE;
      WRITING:     next = write_active ? WRITING : DONE;
      DONE:        next = last_sel ? AWAIT_SWAP : SIGNAL;
      AWAIT_SWAP:  next = frame ? REFILL : AWAIT_SWAP;
      default:     next = REFILL;
    endcase
  end

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= REFILL;
      write_source_sel <= '0;
      write_awaited <= 1'b0;
      frames_missed <= '0;
      clear_addr <= '0;
      active_fb <= 1'b0;
      read_color_data <= '0;
    end else begin
      state <= next;
      write_awaited <= next == AWAIT_WRITE;
      clear_addr <= (clear_busy && !clear_last) ? clear_addr + AW'(1) : '0;
      write_source_sel <= clear_busy ? '0 :
                          state == DONE ? (last_sel ? '0 : write_source_sel + SEL_W'(1)) :
                          write_source_sel;
      active_fb <= active_fb ^ (state == AWAIT_SWAP && frame);
      frames_missed <= (frame && state != AWAIT_SWAP && frames_missed != 8'hFF) ?
                       frames_missed + 8'd1 : frames_missed;
      // buffer choice is the active_fb of the address cycle, so a swap edge never splits a read
      read_color_data <= rd_ok ? (active_fb ? mem1[raddr] : mem0[raddr]) : CLEAR_COLOR;
    end

  always_ff @(posedge clk) begin
    if (we && active_fb) mem0[waddr] <= wdata;
    if (we && !active_fb) mem1[waddr] <= wdata;
  end
endmodule

// File: tb/tb_frame_manager_multi.sv
// tb_frame_manager_multi: randomized scoreboard bench; a pixel-array model of both buffers predicts
// grants, read data and the missed-frame count.
module tb_frame_manager_multi;
  localparam int N = 2, DW = 12, DH = 6, S = 1, XW = 4, YW = 3;
  localparam int SW = DW >> S, SH = DH >> S, DEPTH = SW * SH;
  localparam logic [7:0] CC = 8'h5A;

  logic clk = 1'b0, resetN = 1'b0, frame = 1'b0;
  logic [N-1:0] source_enable = '0;
  logic write_active = 1'b0, write_transparent = 1'b0;
  logic [7:0] write_color_data = '0;
  logic [XW-1:0] write_x_addr = '0, read_x_addr = '0;
  logic [YW-1:0] write_y_addr = '0, read_y_addr = '0;
  logic write_awaited, clear_busy;
  logic [0:0] write_source_sel;
  logic [7:0] read_color_data, frames_missed;

  frame_manager_multi #(.NUM_SOURCES(N), .COLOR_DEPTH(8), .DRAW_WIDTH(DW), .DRAW_HEIGHT(DH),
    .SCALE_SHR(S), .CLEAR_ON_SWAP(1), .CLEAR_COLOR(CC)) dut (
    .clk(clk), .resetN(resetN), .frame(frame), .source_enable(source_enable),
    .write_active(write_active), .write_transparent(write_transparent),
    .write_color_data(write_color_data), .write_x_addr(write_x_addr), .write_y_addr(write_y_addr),
    .write_awaited(write_awaited), .write_source_sel(write_source_sel),
    .read_x_addr(read_x_addr), .read_y_addr(read_y_addr), .read_color_data(read_color_data),
    .clear_busy(clear_busy), .frames_missed(frames_missed));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [7:0] rdq[$];
  int gq[$];
  logic [7:0] fb [2][DEPTH];
  bit model_active, front_valid;
  int missed;
  logic rd_v = 1'b0, rd_d, aw_prev;
  int clr_cnt;

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  function automatic int addr(input int x, input int y);
    return (y / (1 << S)) * SW + x / (1 << S);
  endfunction

  function automatic bit inr(input int x, input int y);
    return x < DW && y < DH;
  endfunction

  always @(posedge clk or negedge resetN)
    if (!resetN) rd_d <= 1'b0;
    else rd_d <= rd_v;

  always @(negedge clk)
    if (!resetN) begin
      clr_cnt <= 0;
      aw_prev <= 1'b0;
    end else begin
      aw_prev <= write_awaited;
      if (rd_d) begin
        if (rdq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL read_unexpected: data %0h with nothing expected", read_color_data);
        end else chk("read_data", int'(read_color_data), int'(rdq.pop_front()));
      end
      if (write_awaited && !aw_prev) begin
        if (gq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL grant_unexpected: sel %0d with no grant expected", write_source_sel);
        end else chk("grant_sel", int'(write_source_sel), gq.pop_front());
      end
      if (clear_busy) clr_cnt <= clr_cnt + 1;
      else if (clr_cnt != 0) begin
        chk("clear_len", clr_cnt, DEPTH);
        clr_cnt <= 0;
      end
    end

  task automatic model_reset();
    model_active = 0;
    missed = 0;
    front_valid = 0;
    for (int i = 0; i < DEPTH; i++) fb[1][i] = CC;
  endtask

  task automatic issue_read();
    int x, y;
    x = $urandom_range(15);
    y = $urandom_range(7);
    if (inr(x, y) && !front_valid) rd_v = 1'b0;
    else begin
      read_x_addr = XW'(x);
      read_y_addr = YW'(y);
      rdq.push_back(inr(x, y) ? fb[model_active][addr(x, y)] : CC);
      rd_v = 1'b1;
    end
  endtask

  task automatic tick(input bit swap);
    issue_read();
    @(posedge clk); #1;
    if (frame) begin
      if (swap) begin
        model_active = !model_active;
        for (int i = 0; i < DEPTH; i++) fb[!model_active][i] = CC;
        front_valid = 1;
      end else missed = missed == 255 ? 255 : missed + 1;
      frame = 1'b0;
    end
  endtask

  task automatic wait_grant();
    int i = 0;
    while (!write_awaited && i < 200) begin
      frame = $urandom_range(7) == 0;
      tick(0);
      i++;
    end
    if (!write_awaited) begin
      n_chk++; n_fail++;
      $display("FAIL grant_timeout: write_awaited still %0d after %0d cycles", write_awaited, i);
    end
  endtask

  task automatic reset_mid();
    write_active = 1'b0;
    frame = 1'b0;
    rd_v = 1'b0;
    resetN = 1'b0;
    #1;
    rdq.delete();
    gq.delete();
    model_reset();
    chk("rst_mid_awaited", int'(write_awaited), 0);
    chk("rst_mid_sel", int'(write_source_sel), 0);
    chk("rst_mid_missed", int'(frames_missed), 0);
    chk("rst_mid_clear_busy", int'(clear_busy), 1);
    chk("rst_mid_read", int'(read_color_data), 0);
    @(posedge clk); #1;
    resetN = 1'b1;
  endtask

  task automatic do_frame(input logic [N-1:0] mask, input int npix, input int nmiss, input int rst_at);
    bit first = 1;
    int x, y, i;
    source_enable = mask;
    for (int s = 0; s < N; s++) begin
      if (!mask[s]) continue;
      gq.push_back(s);
      wait_grant();
      for (int k = 0; k < npix; k++) begin
        if (rst_at >= 0 && s == N - 1 && k == rst_at) begin
          reset_mid();
          return;
        end
        x = $urandom_range(15);
        y = $urandom_range(7);
        write_active = 1'b1;
        write_x_addr = XW'(x);
        write_y_addr = YW'(y);
        write_color_data = 8'($urandom);
        write_transparent = $urandom_range(3) == 0;
        frame = first && k < nmiss;
        if (!write_transparent && inr(x, y)) fb[!model_active][addr(x, y)] = write_color_data;
        tick(0);
      end
      write_active = 1'b0;
      first = 0;
    end
    i = 0;
    while (clear_busy && i < 100) begin
      tick(0);
      i++;
    end
    repeat (2 * N + 2) tick(0);
    chk("missed_before_swap", int'(frames_missed), missed);
    frame = 1'b1;
    tick(1);
    chk("missed_after_swap", int'(frames_missed), missed);
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst_clear_busy", int'(clear_busy), 1);
    chk("rst_awaited", int'(write_awaited), 0);
    chk("rst_sel", int'(write_source_sel), 0);
    chk("rst_missed", int'(frames_missed), 0);
    chk("rst_read", int'(read_color_data), 0);
    @(posedge clk); #1;
    resetN = 1'b1;
    do_frame(2'b11, 6, 0, -1);
    do_frame(2'b11, 8, 0, -1);
    do_frame(2'b10, 6, 0, -1);
    do_frame(2'b01, 10, 3, -1);
    do_frame(2'b00, 0, 0, -1);
    do_frame(2'b11, 310, 300, -1);
    chk("missed_saturated", int'(frames_missed), 255);
    for (int f = 0; f < 5; f++) do_frame(N'($urandom_range(3)), $urandom_range(1, 20), $urandom_range(2), -1);
    do_frame(2'b11, 6, 0, 3);
    do_frame(2'b11, 5, 0, -1);
    do_frame(2'b11, 5, 0, -1);
    do_frame(2'b01, 4, 0, -1);
    rd_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("read_queue_drained", rdq.size(), 0);
    chk("grant_queue_drained", gq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
